// File: rtl/vdp_cpu_bus_if.sv
//==============================================================================
// vdp_cpu_bus_if : downstream write/read handshake bundle for vdp_cpu_bus
// Revision 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vdp_cpu_bus_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_port;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       rd_port;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       wr_overflow;

  modport master (
    output wr_valid, wr_port, wr_data, rd_req, rd_port, wr_overflow,
    input  wr_ready, rd_ack, rd_data
  );

  modport slave (
    input  wr_valid, wr_port, wr_data, rd_req, rd_port, wr_overflow,
    output wr_ready, rd_ack, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/vdp_cpu_bus.sv
//==============================================================================
// vdp_cpu_bus : Z80 I/O strobe front-end with write FIFO and ordered reads
// Revision 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module vdp_cpu_bus #(
  parameter logic [7:0] VRAM_PORT  = 8'h01,
  parameter logic [7:0] VDP_PORT   = 8'h02,
  parameter int         FIFO_DEPTH = 4
) (
  input  wire logic       clk40m,
  input  wire logic       rst_n,
  input  wire logic [7:0] cpu_a,
  input  wire logic [7:0] cpu_d_in,
  output logic      [7:0] cpu_d_out,
  output logic            cpu_d_oe,
  input  wire logic       cpu_in_n,
  input  wire logic       cpu_out_n,
  vdp_cpu_bus_if.master   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REQ   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // bit0 = s1, bit1 = s2, bit2 = s3 (history)
  logic [2:0] in_sync_q, out_sync_q;

  logic [AW:0] wp_q, rp_q;
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic        overflow_q;

  state_t      state_q, state_d;
  logic        rd_port_q, rd_port_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;

  logic in_fall, out_fall, match, port_sel;
  logic out_hit, in_hit, empty, full, pop, push;
  logic [8:0] head;

  always_ff @(posedge clk40m) begin
    if (!rst_n) begin
      in_sync_q  <= 3'b000;
      out_sync_q <= 3'b000;
    end else begin
      in_sync_q  <= {in_sync_q[1:0], cpu_in_n};
      out_sync_q <= {out_sync_q[1:0], cpu_out_n};
    end
  end

  assign in_fall  = in_sync_q[2] & ~in_sync_q[1];
  assign out_fall = out_sync_q[2] & ~out_sync_q[1];

  assign match    = (cpu_a == VRAM_PORT) || (cpu_a == VDP_PORT);
  assign port_sel = (cpu_a != VRAM_PORT);

  // A simultaneous OUT edge wins; the IN edge is discarded.
  assign out_hit = out_fall & match;
  assign in_hit  = in_fall & match & ~out_fall;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = ~empty & bus.wr_ready;
  assign push  = out_hit & (~full | pop);

  always_ff @(posedge clk40m) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (pop)  rp_q <= rp_q + PTR_ONE;
      if (out_hit && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk40m) begin
    if (push) mem_q[wp_q[AW-1:0]] <= {port_sel, cpu_d_in};
  end

  assign head            = mem_q[rp_q[AW-1:0]];
  assign bus.wr_valid    = ~empty;
  assign bus.wr_port     = head[8];
  assign bus.wr_data     = head[7:0];
  assign bus.wr_overflow = overflow_q;

  always_ff @(posedge clk40m) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_port_q <= 1'b0;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_port_q <= rd_port_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_port_d = rd_port_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hit) begin
          rd_port_d = port_sel;
          oe_d      = 1'b1;
          state_d   = empty ? ST_REQ : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A write landing this cycle must also go out ahead of the read.
        if (empty && !push) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.rd_ack) begin
          dout_d  = bus.rd_data;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (in_sync_q[1]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (in_sync_q[1]) oe_d = 1'b0;
  end

  assign bus.rd_req  = (state_q == ST_REQ);
  assign bus.rd_port = rd_port_q;
  assign cpu_d_out   = dout_q;
  assign cpu_d_oe    = oe_q;

endmodule

`default_nettype wire
